// File: rtl/fcmp_arbiter_if.sv
// rtl/fcmp_arbiter_if.sv - request/response bundle between compare requesters and the arbiter
interface fcmp_arbiter_if #(
    parameter int BUS_WIDTH = 64
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [2:0]           req0_op;
    logic [BUS_WIDTH-1:0] req0_a;
    logic [BUS_WIDTH-1:0] req0_b;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [2:0]           req1_op;
    logic [BUS_WIDTH-1:0] req1_a;
    logic [BUS_WIDTH-1:0] req1_b;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [BUS_WIDTH-1:0] rsp_result;
    logic                 rsp_nv;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_nv
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_nv
    );
endinterface

// File: rtl/fcmp_arbiter.sv
// rtl/fcmp_arbiter.sv - round-robin front-end for the shared FEQ/FLT/FLE compare unit
module fcmp_arbiter #(
    parameter int BUS_WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    fcmp_arbiter_if.slave bus
);
    localparam int EXP_W = (BUS_WIDTH == 32) ? 8 : 11;
    localparam int MAN_W = BUS_WIDTH - 1 - EXP_W;

    localparam logic [2:0] OP_FLE = 3'b000;
    localparam logic [2:0] OP_FLT = 3'b001;
    localparam logic [2:0] OP_FEQ = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic                 ptr_q;
    logic                 grant_id;
    logic                 accept;

    logic [2:0]           op_q;
    logic [BUS_WIDTH-1:0] a_q;
    logic [BUS_WIDTH-1:0] b_q;
    logic                 id_q;

    logic                 rsp_result_q;
    logic                 rsp_nv_q;
    logic                 rsp_id_q;

    logic                 a_sign;
    logic                 b_sign;
    logic [BUS_WIDTH-2:0] a_mag;
    logic [BUS_WIDTH-2:0] b_mag;
    logic                 a_nan;
    logic                 b_nan;
    logic                 a_snan;
    logic                 b_snan;
    logic                 both_zero;
    logic                 ord_eq;
    logic                 ord_lt;
    logic                 cmp_result;
    logic                 cmp_nv;

    // Grant: a lone requester wins outright, contention is settled by ptr
    always_comb begin
        grant_id = ptr_q;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant_id = 1'b0;
        end else if (!bus.req0_valid && bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is held low during the reset cycle so nothing is accepted into a clearing pipeline
    assign bus.req0_ready = (state_q == ST_IDLE) && !rst && bus.req0_valid && (grant_id == 1'b0);
    assign bus.req1_ready = (state_q == ST_IDLE) && !rst && bus.req1_valid && (grant_id == 1'b1);
    assign accept         = bus.req0_ready || bus.req1_ready;

    // Next-state: one cycle to evaluate, then hold the response until it is consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EVAL;
            ST_EVAL: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and round-robin pointer; the pointer only moves when a request is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q <= ~grant_id;
            end
        end
    end

    // Operand capture from the granted requester at the handshake edge
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= 3'b000;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            op_q <= grant_id ? bus.req1_op : bus.req0_op;
            a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
            b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
            id_q <= grant_id;
        end
    end

    // Field decode and ordering of the registered operands
    always_comb begin
        a_sign    = a_q[BUS_WIDTH-1];
        b_sign    = b_q[BUS_WIDTH-1];
        a_mag     = a_q[BUS_WIDTH-2:0];
        b_mag     = b_q[BUS_WIDTH-2:0];
        a_nan     = (&a_q[BUS_WIDTH-2 -: EXP_W]) && (|a_q[MAN_W-1:0]);
        b_nan     = (&b_q[BUS_WIDTH-2 -: EXP_W]) && (|b_q[MAN_W-1:0]);
        a_snan    = a_nan && !a_q[MAN_W-1];
        b_snan    = b_nan && !b_q[MAN_W-1];
        both_zero = (a_mag == '0) && (b_mag == '0);
        ord_eq    = both_zero || (a_q == b_q);
        // Sign-magnitude order: opposite signs decide by sign, negatives reverse magnitude
        if (both_zero) begin
            ord_lt = 1'b0;
        end else if (a_sign != b_sign) begin
            ord_lt = a_sign;
        end else if (!a_sign) begin
            ord_lt = (a_mag < b_mag);
        end else begin
            ord_lt = (a_mag > b_mag);
        end
    end

    // Result and invalid flag per funct3; FEQ is quiet, FLT/FLE signal on any NaN
    always_comb begin
        cmp_result = 1'b0;
        cmp_nv     = 1'b0;
        case (op_q)
            OP_FEQ: begin
                cmp_result = !(a_nan || b_nan) && ord_eq;
                cmp_nv     = a_snan || b_snan;
            end
            OP_FLT: begin
                cmp_result = !(a_nan || b_nan) && ord_lt;
                cmp_nv     = a_nan || b_nan;
            end
            OP_FLE: begin
                cmp_result = !(a_nan || b_nan) && (ord_lt || ord_eq);
                cmp_nv     = a_nan || b_nan;
            end
            default: begin
                cmp_result = 1'b0;
                cmp_nv     = 1'b0;
            end
        endcase
    end

    // Response payload is loaded only in EVAL, so it stays frozen under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result_q <= 1'b0;
            rsp_nv_q     <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else if (state_q == ST_EVAL) begin
            rsp_result_q <= cmp_result;
            rsp_nv_q     <= cmp_nv;
            rsp_id_q     <= id_q;
        end
    end

    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = {{(BUS_WIDTH-1){1'b0}}, rsp_result_q};
    assign bus.rsp_nv     = rsp_nv_q;
endmodule

// File: tb/tb_fcmp_arbiter.sv
// tb/tb_fcmp_arbiter.sv - scoreboard bench for fcmp_arbiter with a real-valued reference model
module tb_fcmp_arbiter;
    localparam int BW = 64;

    localparam logic [2:0]  OP_FLE = 3'b000;
    localparam logic [2:0]  OP_FLT = 3'b001;
    localparam logic [2:0]  OP_FEQ = 3'b010;
    localparam logic [2:0]  OP_RSV = 3'b011;
    localparam logic [63:0] ONE    = 64'h3FF0000000000000;
    localparam logic [63:0] TWO    = 64'h4000000000000000;
    localparam logic [63:0] MONE   = 64'hBFF0000000000000;
    localparam logic [63:0] MTWO   = 64'hC000000000000000;
    localparam logic [63:0] NZERO  = 64'h8000000000000000;
    localparam logic [63:0] QNAN   = 64'h7FF8000000000000;
    localparam logic [63:0] SNAN   = 64'h7FF0000000000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fcmp_arbiter_if #(.BUS_WIDTH(BW)) bus ();
    fcmp_arbiter #(.BUS_WIDTH(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic id;
        logic res;
        logic nv;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rsp_seen = 0;
    int   cyc      = 0;
    bit   done     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'h0);
    endfunction

    // Reference: IEEE numeric comparison on real values, NaNs classified from the bit pattern
    function automatic exp_t model(input logic id, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        real  ra;
        real  rb;
        bit   any_nan;
        bit   any_snan;
        ra       = $bitstoreal(a);
        rb       = $bitstoreal(b);
        any_nan  = is_nan(a) || is_nan(b);
        any_snan = (is_nan(a) && !a[51]) || (is_nan(b) && !b[51]);
        e.id  = id;
        e.res = 1'b0;
        e.nv  = 1'b0;
        case (op)
            OP_FEQ: begin e.res = !any_nan && (ra == rb); e.nv = any_snan; end
            OP_FLT: begin e.res = !any_nan && (ra <  rb); e.nv = any_nan;  end
            OP_FLE: begin e.res = !any_nan && (ra <= rb); e.nv = any_nan;  end
            default: begin e.res = 1'b0; e.nv = 1'b0; end
        endcase
        return e;
    endfunction

    function automatic logic [63:0] rand_fp();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0: return 64'h0;
            1: return NZERO;
            2: return ONE;
            3: return MONE;
            4: return {r[63], 11'h7FF, 1'b1, r[50:0]};
            5: return {r[63], 11'h7FF, 1'b0, r[50:1], 1'b1};
            6: return {r[63], 11'h7FF, 52'h0};
            default: return r;
        endcase
    endfunction

    function automatic logic [2:0] rand_op();
        if ($urandom_range(0, 7) == 0) return 3'($urandom_range(3, 7));
        return 3'($urandom_range(0, 2));
    endfunction

    task automatic drive(input int p, input logic v, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    // Present a request (called just after a rising edge) and hold it until accepted
    task automatic issue(input int p, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        bit got;
        got = 1'b0;
        drive(p, 1'b1, op, a, b);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy(p)) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        drive(p, 1'b0, op, a, b);
        if (!got) begin
            n_checks++;
            $display("FAIL accept_timeout: port %0d not granted within 200 cycles", p);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        @(posedge clk); #1;
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic rand_port(input int p, input int n);
        logic [63:0] a;
        logic [63:0] b;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            a = rand_fp();
            b = ($urandom_range(0, 3) == 0) ? a : rand_fp();
            issue(p, rand_op(), a, b);
        end
    endtask

    // Acceptance monitor: every handshake pushes the model's expected response
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_valid && bus.req0_ready) sb.push_back(model(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
            if (bus.req1_valid && bus.req1_ready) sb.push_back(model(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
        end
    end

    // Response monitor: every consumed response is checked against the oldest expectation
    always @(negedge clk) begin : rsp_mon
        exp_t e;
        if (!rst && bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
            rsp_seen++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got response id %0d result %h, expected no response", bus.rsp_id, bus.rsp_result);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                check("rsp_result", bus.rsp_result, {63'h0, e.res});
                check("rsp_nv", 64'(bus.rsp_nv), 64'(e.nv));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  d_op [7];
        logic [63:0] d_a  [7];
        logic [63:0] d_b  [7];
        int          ids  [$];
        int          cycs [$];
        exp_t        e_bp;
        int          seen_before;
        bit          got;
        int          p;

        drive(0, 1'b0, OP_FLE, 64'h0, 64'h0);
        drive(1, 1'b0, OP_FLE, 64'h0, 64'h0);
        bus.rsp_ready = 1'b1;
        rst = 1'b1;

        // Reset held two cycles with req0 waiting
        drive(0, 1'b1, OP_FLT, ONE, TWO);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            check("reset_rsp_result", bus.rsp_result, 64'h0);
            check("reset_rsp_nv", 64'(bus.rsp_nv), 64'(0));
            check("reset_rsp_id", 64'(bus.rsp_id), 64'(0));
            check("reset_req0_ready", 64'(bus.req0_ready), 64'(0));
            check("reset_req1_ready", 64'(bus.req1_ready), 64'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("grant_after_reset", 64'(bus.req0_ready), 64'(1));
        @(posedge clk); #1;
        drive(0, 1'b0, OP_FLT, ONE, TWO);
        check("eval_no_rsp", 64'(bus.rsp_valid), 64'(0));
        @(posedge clk); #1;
        check("rsp_latency", 64'(bus.rsp_valid), 64'(1));
        drain();

        // Directed compares: equal ones, signed zeros, negatives, NaN flags, reserved op
        d_op[0] = OP_FLE; d_a[0] = ONE;   d_b[0] = ONE;
        d_op[1] = OP_FEQ; d_a[1] = NZERO; d_b[1] = 64'h0;
        d_op[2] = OP_FLT; d_a[2] = MTWO;  d_b[2] = MONE;
        d_op[3] = OP_FEQ; d_a[3] = QNAN;  d_b[3] = ONE;
        d_op[4] = OP_FEQ; d_a[4] = SNAN;  d_b[4] = ONE;
        d_op[5] = OP_FLE; d_a[5] = QNAN;  d_b[5] = ONE;
        d_op[6] = OP_RSV; d_a[6] = ONE;   d_b[6] = TWO;
        for (int i = 0; i < 7; i++) begin
            issue(i % 2, d_op[i], d_a[i], d_b[i]);
            drain();
        end

        // Round-robin under continuous contention, starting from ptr = 0
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b1, rand_op(), rand_fp(), rand_fp());
        drive(1, 1'b1, rand_op(), rand_fp(), rand_fp());
        for (int k = 0; k < 60 && ids.size() < 4; k++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                p = bus.req1_ready ? 1 : 0;
                ids.push_back(p);
                cycs.push_back(cyc);
                @(posedge clk); #1;
                drive(p, 1'b1, rand_op(), rand_fp(), rand_fp());
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, OP_FLE, 64'h0, 64'h0);
        drive(1, 1'b0, OP_FLE, 64'h0, 64'h0);
        check("rr_count", 64'(ids.size()), 64'(4));
        for (int i = 0; i < ids.size(); i++) begin
            check("rr_grant", 64'(ids[i]), 64'(i % 2));
            if (i > 0) check("rr_spacing", 64'(cycs[i] - cycs[i-1]), 64'(3));
        end
        drain();

        // Randomized traffic on both ports with random consumer backpressure
        fork
            begin
                fork
                    rand_port(0, 30);
                    rand_port(1, 30);
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    if (!done) bus.rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.rsp_ready = 1'b1;
        drain();

        // Backpressure for 5 cycles in RESP with req1 waiting
        bus.rsp_ready = 1'b0;
        e_bp = model(1'b0, OP_FLT, MTWO, MONE);
        issue(0, OP_FLT, MTWO, MONE);
        drive(1, 1'b1, OP_FEQ, ONE, ONE);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
            check("bp_rsp_result", bus.rsp_result, {63'h0, e_bp.res});
            check("bp_rsp_nv", 64'(bus.rsp_nv), 64'(e_bp.nv));
            check("bp_rsp_id", 64'(bus.rsp_id), 64'(e_bp.id));
            check("bp_req0_ready", 64'(bus.req0_ready), 64'(0));
            check("bp_req1_ready", 64'(bus.req1_ready), 64'(0));
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;

        // Reset while req1's request sits in EVAL: it must vanish
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req1_ready) begin got = 1'b1; break; end
        end
        check("req1_accepted", 64'(got), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 1'b0, OP_FLE, 64'h0, 64'h0);
        sb.delete();
        seen_before = rsp_seen;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("no_rsp_after_reset", 64'(rsp_seen), 64'(seen_before));
        check("idle_after_reset", 64'(bus.rsp_valid), 64'(0));
        @(posedge clk); #1;
        drive(0, 1'b1, OP_FEQ, NZERO, 64'h0);
        drive(1, 1'b1, OP_FLT, ONE, TWO);
        @(negedge clk);
        check("ptr0_req0_ready", 64'(bus.req0_ready), 64'(1));
        check("ptr0_req1_ready", 64'(bus.req1_ready), 64'(0));
        @(posedge clk); #1;
        drive(0, 1'b0, OP_FLE, 64'h0, 64'h0);
        issue(1, OP_FLT, ONE, TWO);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
